// File: rtl/decode_hazard_unit.sv
// decode_hazard_unit: drives the decode/execute control word, injecting bubbles for
// load-use hazards (stall) and for taken branches in execute (flush).
module decode_hazard_unit #(
   parameter int LOAD_STALL_CYCLES  = 1,
   parameter int FLUSH_CYCLES       = 1,
   parameter int ZERO_REG_HARDWIRED = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] control_word_decode,
   input  logic [3:0]  rs1_decode,
   input  logic [3:0]  rs2_decode,
   input  logic        rs1_used_decode,
   input  logic        rs2_used_decode,
   input  logic [3:0]  rd_execute,
   input  logic        load_instruction,
   input  logic        branch_taken_execute,
   output logic [15:0] nop_mux_output,
   output logic        stall_fetch,
   output logic        stall_decode,
   output logic        flush_fetch,
   output logic [15:0] stall_count
);
   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
   localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL_CYCLES - 2);
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] count_q, count_d;
   logic        hazard;
   always_comb begin
      hazard = load_instruction &
               ((rs1_used_decode & (rs1_decode == rd_execute)) |
                (rs2_used_decode & (rs2_decode == rd_execute))) &
               !((ZERO_REG_HARDWIRED != 0) && (rd_execute == 4'd0));
      state_d        = state_q;
      cnt_d          = cnt_q;
      nop_mux_output = control_word_decode;
      stall_fetch    = 1'b0;
      stall_decode   = 1'b0;
      flush_fetch    = 1'b0;
      // A taken branch wins in every state; inside FLUSH it reloads the counter.
      if (branch_taken_execute) begin
         flush_fetch    = 1'b1;
         nop_mux_output = 16'h0000;
         state_d        = (FLUSH_CYCLES > 0) ? FLUSH : RUN;
         cnt_d          = FLUSH_INIT;
      end else if (state_q == FLUSH) begin
         flush_fetch    = 1'b1;
         nop_mux_output = 16'h0000;
         state_d        = (cnt_q == 4'd0) ? RUN : FLUSH;
         cnt_d          = cnt_q - 4'd1;
      end else if (state_q == STALL) begin
         stall_fetch    = 1'b1;
         stall_decode   = 1'b1;
         nop_mux_output = 16'h0000;
         state_d        = (cnt_q == 4'd0) ? RUN : STALL;
         cnt_d          = cnt_q - 4'd1;
      end else if (hazard) begin
         stall_fetch    = 1'b1;
         stall_decode   = 1'b1;
         nop_mux_output = 16'h0000;
         state_d        = (LOAD_STALL_CYCLES > 1) ? STALL : RUN;
         cnt_d          = STALL_INIT;
      end
      if (reset) begin
         nop_mux_output = 16'h0000;
         stall_fetch    = 1'b0;
         stall_decode   = 1'b0;
         flush_fetch    = 1'b0;
      end
      count_d = ((stall_fetch | flush_fetch) && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
      stall_count = count_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= 4'd0;
         count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_decode_hazard_unit.sv
// tb_decode_hazard_unit: directed checks on two instances
// (a: 1 stall / 1 flush / r0 hardwired, b: 3 stalls / 2 flushes / r0 not hardwired).
module tb_decode_hazard_unit;
   logic        clk = 1'b0, reset = 1'b1;
   logic [15:0] cw = 16'h0;
   logic [3:0]  rs1 = 4'd0, rs2 = 4'd0, rd = 4'd0;
   logic        u1 = 1'b0, u2 = 1'b0, ld = 1'b0, br = 1'b0;
   logic [15:0] a_nop, b_nop, a_cnt, b_cnt;
   logic        a_sf, a_sd, a_ff, b_sf, b_sd, b_ff;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   decode_hazard_unit #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .ZERO_REG_HARDWIRED(1)) u_a (
      .clk(clk), .reset(reset), .control_word_decode(cw), .rs1_decode(rs1), .rs2_decode(rs2),
      .rs1_used_decode(u1), .rs2_used_decode(u2), .rd_execute(rd), .load_instruction(ld),
      .branch_taken_execute(br), .nop_mux_output(a_nop), .stall_fetch(a_sf), .stall_decode(a_sd),
      .flush_fetch(a_ff), .stall_count(a_cnt));
   decode_hazard_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .ZERO_REG_HARDWIRED(0)) u_b (
      .clk(clk), .reset(reset), .control_word_decode(cw), .rs1_decode(rs1), .rs2_decode(rs2),
      .rs1_used_decode(u1), .rs2_used_decode(u2), .rd_execute(rd), .load_instruction(ld),
      .branch_taken_execute(br), .nop_mux_output(b_nop), .stall_fetch(b_sf), .stall_decode(b_sd),
      .flush_fetch(b_ff), .stall_count(b_cnt));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [15:0] c, input logic [3:0] s1, input logic [3:0] s2,
                         input logic us1, input logic us2, input logic [3:0] d, input logic l,
                         input logic b);
      cw = c; rs1 = s1; rs2 = s2; u1 = us1; u2 = us2; rd = d; ld = l; br = b;
      #1;
   endtask

   task automatic do_reset();
      set_in(16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      set_in(16'h1234, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
      tick();
      total++; if (a_nop !== 16'h0) begin bad++; $display("FAIL reset_a_nop got %h exp 0000", a_nop); end
      total++; if ({a_sf, a_sd, a_ff, b_sf, b_sd, b_ff} !== 6'b0) begin bad++; $display("FAIL reset_ctl got %b exp 000000", {a_sf, a_sd, a_ff, b_sf, b_sd, b_ff}); end
      total++; if (a_cnt !== 16'h0 || b_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got %h/%h exp 0000", a_cnt, b_cnt); end
      reset = 1'b0;
      set_in(16'h1234, 4'd3, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
      total++; if (a_nop !== 16'h1234) begin bad++; $display("FAIL reset_pass got %h exp 1234", a_nop); end
   endtask

   task automatic test_load_stall_1();
      do_reset();
      set_in(16'h01A5, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
      total++; if (a_nop !== 16'h0) begin bad++; $display("FAIL ls1_nop got %h exp 0000", a_nop); end
      total++; if ({a_sf, a_sd, a_ff} !== 3'b110) begin bad++; $display("FAIL ls1_ctl got %b exp 110", {a_sf, a_sd, a_ff}); end
      tick();
      set_in(16'h01A5, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
      total++; if (a_nop !== 16'h01A5 || a_sf !== 1'b0) begin bad++; $display("FAIL ls1_issue got %h/%b exp 01a5/0", a_nop, a_sf); end
      total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL ls1_cnt got %0d exp 1", a_cnt); end
   endtask

   task automatic test_load_stall_3();
      do_reset();
      set_in(16'h00F7, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         total++; if (b_nop !== 16'h0 || b_sf !== 1'b1 || b_sd !== 1'b1) begin bad++; $display("FAIL ls3_bubble%0d got %h/%b%b exp 0000/11", i, b_nop, b_sf, b_sd); end
         tick();
      end
      set_in(16'h00F7, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
      total++; if (b_nop !== 16'h00F7 || b_sf !== 1'b0) begin bad++; $display("FAIL ls3_issue got %h/%b exp 00f7/0", b_nop, b_sf); end
      total++; if (b_cnt !== 16'd3) begin bad++; $display("FAIL ls3_cnt got %0d exp 3", b_cnt); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      set_in(16'h0155, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      total++; if (a_nop !== 16'h0155 || a_sf !== 1'b0) begin bad++; $display("FAIL zr_a got %h/%b exp 0155/0", a_nop, a_sf); end
      total++; if (b_nop !== 16'h0 || b_sf !== 1'b1) begin bad++; $display("FAIL zr_b got %h/%b exp 0000/1", b_nop, b_sf); end
      set_in(16'h0155, 4'd2, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
      total++; if (a_nop !== 16'h0155 || a_sf !== 1'b0) begin bad++; $display("FAIL rs2_unused got %h/%b exp 0155/0", a_nop, a_sf); end
      set_in(16'h0155, 4'd2, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
      total++; if (a_nop !== 16'h0 || a_sf !== 1'b1) begin bad++; $display("FAIL rs2_used got %h/%b exp 0000/1", a_nop, a_sf); end
   endtask

   task automatic test_branch_hazard();
      do_reset();
      set_in(16'h00C3, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1);
      total++; if ({a_sf, a_sd, a_ff} !== 3'b001 || a_nop !== 16'h0) begin bad++; $display("FAIL br_c1_a got %b/%h exp 001/0000", {a_sf, a_sd, a_ff}, a_nop); end
      total++; if ({b_sf, b_sd, b_ff} !== 3'b001) begin bad++; $display("FAIL br_c1_b got %b exp 001", {b_sf, b_sd, b_ff}); end
      tick();
      set_in(16'h00C3, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
      total++; if ({a_sf, a_ff} !== 2'b01 || {b_sf, b_ff} !== 2'b01) begin bad++; $display("FAIL br_c2 got %b%b exp 0101", {a_sf, a_ff}, {b_sf, b_ff}); end
      tick();
      set_in(16'h00C3, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
      total++; if (a_ff !== 1'b0 || a_nop !== 16'h00C3) begin bad++; $display("FAIL br_c3_a got %b/%h exp 0/00c3", a_ff, a_nop); end
      total++; if (b_ff !== 1'b1 || b_nop !== 16'h0) begin bad++; $display("FAIL br_c3_b got %b/%h exp 1/0000", b_ff, b_nop); end
      tick();
      total++; if (b_ff !== 1'b0 || b_nop !== 16'h00C3) begin bad++; $display("FAIL br_c4_b got %b/%h exp 0/00c3", b_ff, b_nop); end
      total++; if (a_cnt !== 16'd2 || b_cnt !== 16'd3) begin bad++; $display("FAIL br_cnt got %0d/%0d exp 2/3", a_cnt, b_cnt); end
   endtask

   task automatic test_stall_abort();
      do_reset();
      set_in(16'h0042, 4'd7, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0);
      tick();
      set_in(16'h0042, 4'd7, 4'd0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1);
      total++; if ({b_sf, b_sd, b_ff} !== 3'b001 || b_nop !== 16'h0) begin bad++; $display("FAIL abort_c1 got %b/%h exp 001/0000", {b_sf, b_sd, b_ff}, b_nop); end
      tick();
      set_in(16'h0042, 4'd7, 4'd0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0);
      total++; if ({b_sf, b_ff} !== 2'b01) begin bad++; $display("FAIL abort_c2 got %b exp 01", {b_sf, b_ff}); end
      tick();
      set_in(16'h0042, 4'd7, 4'd0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1);
      total++; if (b_ff !== 1'b1) begin bad++; $display("FAIL reload_c3 got %b exp 1", b_ff); end
      tick();
      set_in(16'h0042, 4'd7, 4'd0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0);
      tick();
      total++; if (b_ff !== 1'b1 || b_nop !== 16'h0) begin bad++; $display("FAIL reload_c5 got %b/%h exp 1/0000", b_ff, b_nop); end
      tick();
      total++; if (b_ff !== 1'b0 || b_nop !== 16'h0042) begin bad++; $display("FAIL reload_end got %b/%h exp 0/0042", b_ff, b_nop); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_in(16'h0099, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
      tick();
      total++; if (b_sf !== 1'b1) begin bad++; $display("FAIL mid_in_stall got %b exp 1", b_sf); end
      #2 reset = 1'b1;
      #1;
      total++; if (b_nop !== 16'h0 || {b_sf, b_sd, b_ff} !== 3'b0 || b_cnt !== 16'h0) begin bad++; $display("FAIL mid_reset got %h/%b/%h exp 0000/000/0000", b_nop, {b_sf, b_sd, b_ff}, b_cnt); end
      reset = 1'b0;
      set_in(16'h0099, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
      total++; if (b_nop !== 16'h0099 || b_sf !== 1'b0) begin bad++; $display("FAIL mid_run got %h/%b exp 0099/0", b_nop, b_sf); end
   endtask

   task automatic test_saturation();
      do_reset();
      set_in(16'h0001, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
      repeat (65534) tick();
      total++; if (a_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got %h exp fffe", a_cnt); end
      repeat (3) tick();
      total++; if (a_cnt !== 16'hFFFF || b_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat got %h/%h exp ffff", a_cnt, b_cnt); end
   endtask

   initial begin
      test_reset();
      test_load_stall_1();
      test_load_stall_3();
      test_zero_reg();
      test_branch_hazard();
      test_stall_abort();
      test_reset_mid_stall();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
